// File: rtl/mloopacc.sv
// Streaming accumulator (wrap / saturate / moving-window / hold) with sticky overflow.
// Define MLOOPACC_SIGNED_EN for two's-complement samples and result; default is unsigned.
module mloopacc #(
  parameter int W_IN  = 10,
  parameter int W_ACC = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  x,
  output logic [W_ACC-1:0] acc,
  output logic             out_valid,
  output logic             ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (W_ACC < W_IN + $clog2(DEPTH)) begin : g_bad_width
    $error("mloopacc: W_ACC must be >= W_IN + clog2(DEPTH)");
  end
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mloopacc: DEPTH must be a power of two in 2..64");
  end

  typedef enum logic [1:0] {
    M_WRAP = 2'b00,
    M_SAT  = 2'b01,
    M_WIN  = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  function automatic logic [W_ACC-1:0] ext(input logic [W_IN-1:0] v);
`ifdef MLOOPACC_SIGNED_EN
    return {{(W_ACC-W_IN){v[W_IN-1]}}, v};
`else
    return {{(W_ACC-W_IN){1'b0}}, v};
`endif
  endfunction

  logic [1:0]       mode_q, mode_d;
  logic [W_IN-1:0]  xr_q, xr_d;
  logic             pend_q, pend_d;
  logic [W_ACC-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             ov_q, ov_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [W_IN-1:0]  win_q [DEPTH];
  logic [W_IN-1:0]  win_d [DEPTH];

  logic             mode_chg, clear_s, accept;
  logic [W_ACC-1:0] xe, old_e, win_sum, sat_val;
  logic [W_ACC:0]   sum_w;
  logic             of;

  always_comb begin
    mode_chg = (mode != mode_q);
    clear_s  = clr | mode_chg;
    in_ready = !rst && !clr && (mode != M_HOLD) && !mode_chg;
    accept   = in_valid & in_ready;

    xe      = ext(xr_q);
    old_e   = ext(win_q[ptr_q]);
    win_sum = acc_q + xe - old_e;
`ifdef MLOOPACC_SIGNED_EN
    sum_w   = {acc_q[W_ACC-1], acc_q} + {xe[W_ACC-1], xe};
    of      = sum_w[W_ACC] ^ sum_w[W_ACC-1];
    // Clamp direction follows the true (W_ACC+1)-bit sign of the sum.
    sat_val = sum_w[W_ACC] ? {1'b1, {(W_ACC-1){1'b0}}} : {1'b0, {(W_ACC-1){1'b1}}};
`else
    sum_w   = {1'b0, acc_q} + {1'b0, xe};
    of      = sum_w[W_ACC];
    sat_val = '1;
`endif

    mode_d = mode;
    xr_d   = accept ? x : xr_q;
    pend_d = accept;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    ov_d   = 1'b0;
    ptr_d  = ptr_q;
    win_d  = win_q;

    if (clear_s) begin
      pend_d = 1'b0;
      acc_d  = '0;
      ovf_d  = 1'b0;
      ptr_d  = '0;
      for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
    end else if (pend_q) begin
      case (mode_e'(mode))
        M_WRAP: begin
          acc_d = sum_w[W_ACC-1:0];
          ovf_d = ovf_q | of;
          ov_d  = 1'b1;
        end
        M_SAT: begin
          acc_d = of ? sat_val : sum_w[W_ACC-1:0];
          ovf_d = ovf_q | of;
          ov_d  = 1'b1;
        end
        M_WIN: begin
          acc_d        = win_sum;
          win_d[ptr_q] = xr_q;
          ptr_d        = ptr_q + PW'(1);
          ov_d         = 1'b1;
        end
        default: ov_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= mode;
      xr_q   <= '0;
      pend_q <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      ov_q   <= 1'b0;
      ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      mode_q <= mode_d;
      xr_q   <= xr_d;
      pend_q <= pend_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      ov_q   <= ov_d;
      ptr_q  <= ptr_d;
      win_q  <= win_d;
    end
  end

  assign acc       = acc_q;
  assign out_valid = ov_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mloopacc.sv
// Bench for mloopacc: directed test-plan steps, then random traffic, against an integer reference model.
module tb_mloopacc;
  localparam int W_IN  = 10;
  localparam int W_ACC = 16;
  localparam int DEPTH = 4;
  localparam longint MOD = longint'(1) << W_ACC;
`ifdef MLOOPACC_SIGNED_EN
  localparam bit     SGN = 1'b1;
  localparam longint LO  = -(longint'(1) << (W_ACC-1));
  localparam longint HI  = (longint'(1) << (W_ACC-1)) - 1;
`else
  localparam bit     SGN = 1'b0;
  localparam longint LO  = 0;
  localparam longint HI  = MOD - 1;
`endif

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic             rst, clr, in_valid, in_ready, out_valid, ovf;
  logic [1:0]       mode;
  logic [W_IN-1:0]  x;
  logic [W_ACC-1:0] acc;

  mloopacc #(.W_IN(W_IN), .W_ACC(W_ACC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .acc(acc), .out_valid(out_valid), .ovf(ovf)
  );

  int checks = 0;
  int failures = 0;

  longint   m_acc = 0;
  bit       m_ovf = 0, m_ov = 0, m_pend = 0;
  logic [1:0] m_prev = 2'b00;
  longint   m_px = 0;
  longint   win[$];

  function automatic longint xval(input logic [W_IN-1:0] v);
    return SGN ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint accval(input logic [W_ACC-1:0] v);
    return SGN ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint wrapv(input longint s);
    longint m;
    m = s % MOD;
    if (m < 0) m += MOD;
    if (SGN && m > HI) m -= MOD;
    return m;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit c, input logic [1:0] md,
                            input bit v, input logic [W_IN-1:0] xv, input bit rdy);
    longint s;
    if (r || c || md != m_prev) begin
      m_acc = 0; m_ovf = 0; m_ov = 0; m_pend = 0;
      win.delete();
      repeat (DEPTH) win.push_back(0);
    end else begin
      m_ov = 0;
      if (m_pend) begin
        s = m_acc + m_px;
        case (md)
          2'b00: begin
            if (s < LO || s > HI) m_ovf = 1;
            m_acc = wrapv(s);
            m_ov = 1;
          end
          2'b01: begin
            if (s > HI) begin m_acc = HI; m_ovf = 1; end
            else if (s < LO) begin m_acc = LO; m_ovf = 1; end
            else m_acc = s;
            m_ov = 1;
          end
          2'b10: begin
            win.push_back(m_px);
            void'(win.pop_front());
            m_acc = 0;
            foreach (win[i]) m_acc += win[i];
            m_ov = 1;
          end
          default: ;
        endcase
      end
      m_pend = v && rdy;
      m_px = xval(xv);
    end
    m_prev = md;
  endtask

  task automatic cyc(input bit r, input bit c, input logic [1:0] md,
                     input bit v, input logic [W_IN-1:0] xv);
    bit exp_rdy;
    rst = r; clr = c; mode = md; in_valid = v; x = xv;
    @(negedge clk);
    exp_rdy = !r && !c && (md != 2'b11) && (md == m_prev);
    chk("in_ready", longint'(in_ready), longint'(exp_rdy));
    @(posedge clk);
    model_edge(r, c, md, v, xv, exp_rdy);
    #1;
    chk("acc", accval(acc), m_acc);
    chk("out_valid", longint'(out_valid), longint'(m_ov));
    chk("ovf", longint'(ovf), longint'(m_ovf));
  endtask

  logic [1:0]      r_md;
  logic [W_IN-1:0] r_x;
  int              tp_x[4] = '{1, 4, 7, 10};

  initial begin
    rst = 1; clr = 0; mode = 0; in_valid = 0; x = 0;
    repeat (2) cyc(1, 0, 2'b00, 0, 0);
    chk("reset_acc", accval(acc), 0);

    // wrap sum 1,4,7,10 back-to-back
    for (int i = 0; i < 4; i++) cyc(0, 0, 2'b00, 1, W_IN'(tp_x[i]));
    cyc(0, 0, 2'b00, 0, 0);
    chk("tp_sum22", accval(acc), 22);
    cyc(0, 0, 2'b00, 0, 0);

    // clear beats a sample offered in the same cycle
    cyc(0, 1, 2'b00, 1, 9);
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    chk("tp_clr_lost", accval(acc), 0);

    // switch to window mode mid-stream
    cyc(0, 0, 2'b00, 1, 3);
    for (int i = 1; i <= 6; i++) cyc(0, 0, 2'b10, 1, W_IN'(i));
    for (int i = 1; i <= 6; i++) cyc(0, 0, 2'b10, 1, W_IN'(i));
    cyc(0, 0, 2'b10, 0, 0);
    chk("tp_win18", accval(acc), 18);

    // hold mode refuses samples and keeps state
    cyc(0, 0, 2'b11, 1, 5);
    cyc(0, 0, 2'b11, 1, 5);

    // wrap overflow with x = all ones
    cyc(0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 2'b00, 1, '1);
    cyc(0, 0, 2'b00, 1, '1);
`ifndef MLOOPACC_SIGNED_EN
    chk("tp_wrap64", accval(acc), 65472);
`endif
    cyc(0, 0, 2'b00, 1, 0);
`ifndef MLOOPACC_SIGNED_EN
    chk("tp_wrap65", accval(acc), 959);
    chk("tp_wrap_ovf", longint'(ovf), 1);
`endif
    repeat (3) cyc(0, 0, 2'b00, 1, 0);

    // saturating sum, same stimulus then x=5
    cyc(0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 65; i++) cyc(0, 0, 2'b01, 1, '1);
    repeat (3) cyc(0, 0, 2'b01, 1, 5);
    cyc(0, 0, 2'b01, 0, 0);
`ifndef MLOOPACC_SIGNED_EN
    chk("tp_sat", accval(acc), 65535);
    chk("tp_sat_ovf", longint'(ovf), 1);
`endif

    // reset while a sample is pending
    cyc(0, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 5);
    cyc(1, 0, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 0, 0);
    chk("tp_rst_pend_ov", longint'(out_valid), 0);

`ifdef MLOOPACC_SIGNED_EN
    cyc(0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 66; i++) cyc(0, 0, 2'b01, 1, 10'h200);
    cyc(0, 0, 2'b01, 0, 0);
    chk("tp_sneg_clamp", accval(acc), -32768);
    chk("tp_sneg_ovf", longint'(ovf), 1);
`endif

    r_md = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 29) == 0) r_md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        r_x = SGN ? (($urandom_range(0, 1) == 1) ? 10'h1FF : 10'h200) : '1;
      else
        r_x = W_IN'($urandom);
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0, r_md,
          $urandom_range(0, 3) != 0, r_x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mloopacc.md
# mloopacc

Parametrised streaming accumulator: the next generation of the lab loop-adder. It takes a registered input sample stream under a valid/ready handshake and keeps a running result in one of three modes: wrapping sum, saturating sum, or moving-window sum over the last DEPTH samples. It has a sticky overflow flag and a synchronous clear. It sits between a sample source and any consumer of the sum, and replaces the fixed 10-bit/16-bit loop adder in the lab datapaths.

## Interface
- W_IN, 10: sample width.
- W_ACC, 16: accumulator width. Must satisfy W_ACC >= W_IN + clog2(DEPTH); elaboration fails otherwise.
- DEPTH, 8: moving-window length, power of two, 2..64.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- clr  input  1  synchronous clear of sum, window and flags; beats an accepted sample in the same cycle.
- mode  input  2  00 wrap sum, 01 saturating sum, 10 window sum, 11 hold.
- in_valid  input  1  sample x present.
- in_ready  output  1  block accepts x this cycle.
- x  input  W_IN  sample.
- acc  output  W_ACC  current result, registered.
- out_valid  output  1  one-cycle pulse: acc updated with a new sample.
- ovf  output  1  sticky overflow flag.

## Operation
- Stage 1 (input register): on accept (in_valid & in_ready), x is captured into xr and a pending bit is set.
- Stage 2 (accumulate): while pending, acc is updated from xr according to mode; out_valid pulses.
- Mode 00: acc <= acc + xr mod 2^W_ACC. ovf is set on carry-out.
- Mode 01: acc <= min(acc + xr, 2^W_ACC-1). ovf is set when the clamp engages.
- Mode 10: a circular buffer of DEPTH entries holds the last samples, zero-filled after clear.
  - Each sample does acc <= acc + xr - oldest, then the write pointer advances and wraps at DEPTH.
  - ovf is never set in this mode, given the width rule.
- Mode 11: no samples are accepted (in_ready=0). acc, buffer and ovf hold.
- Mode change: a change of mode between consecutive cycles acts as clr, and in_ready=0 in the cycle the change is seen. Any in-flight pending sample is dropped.
- in_ready = !rst & !clr & (mode != 11) & no mode change this cycle.
- clr or rst clears:
  - acc=0, ovf=0, buffer entries=0, pointer=0
  - pending=0, out_valid=0
  - the stored previous-mode register is loaded with the current mode.

## Timing
- Reset values: acc=0, out_valid=0, ovf=0, in_ready=0 during the rst cycle.
- Latency: a sample accepted at edge k is reflected in acc after edge k+1. out_valid is high in the cycle following edge k+1.
- Throughput: one sample per cycle; back-to-back accepts are legal.
- A sample accepted in the same cycle as clr or rst is discarded.
- ovf is updated in the same edge as the acc value that caused it. It stays set until clr, rst or a mode change.
- Saturation at exactly 2^W_ACC-1 without exceeding it does not set ovf.
- Mode 10 before DEPTH samples: the missing entries contribute 0, so acc is the sum of all samples so far.
- Reset mid-operation: all state is cleared at that edge, and the pending sample produces no out_valid.

## Configuration
- MLOOPACC_SIGNED_EN defined:
  - x, buffer and acc are two's complement.
  - Mode 00 sets ovf on signed overflow.
  - Mode 01 clamps to [-2^(W_ACC-1), 2^(W_ACC-1)-1] and sets ovf on either clamp.
  - x is sign-extended before addition.
- MLOOPACC_SIGNED_EN not defined: all arithmetic is unsigned and x is zero-extended.

## Test plan
- Mode 00, rst released, x=1,4,7,10 back-to-back -> acc=1,5,12,22 on successive cycles, each starting 2 cycles after the first accept, out_valid high 4 consecutive cycles, ovf=0.
- Mode 00, x=1023 sent 65 times -> after the 64th acc=65472, after the 65th acc=959 with ovf=1; ovf stays 1 with further x=0 samples.
- Mode 01, same stimulus -> 65th result acc=65535, ovf=1; further x=5 keeps acc=65535.
- Mode 10, DEPTH=4, x=1,2,3,4,5,6 -> acc=1,3,6,10,14,18.
- clr asserted together with in_valid, x=9 after acc=22 -> next cycle acc=0, out_valid=0, ovf=0, and the x=9 sample is lost. Mode switch 00->10 mid-stream -> in_ready=0 for one cycle, acc=0.
- rst pulsed for one cycle while a sample is pending -> acc=0, no out_valid pulse. Under MLOOPACC_SIGNED_EN with mode 01 and x=-512 repeated -> acc clamps at -32768 with ovf=1.
